// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display path: active-low glyphs
// (seg[0]=a .. seg[6]=g) and the anode-sample classification.
package seven_seg_pkg;

    localparam int unsigned N_DIGITS = 4;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        AN_IDLE,
        AN_ONE,
        AN_MULTI
    } an_class_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational decode of an active-low segment pattern back to its hex nibble.
module seg7_glyph_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       is_blank,
    output logic       is_legal
);

    always_comb begin
        nibble   = '0;
        is_blank = 1'b0;
        is_legal = 1'b1;
        case (seg)
            GLYPH_0:     nibble = 4'h0;
            GLYPH_1:     nibble = 4'h1;
            GLYPH_2:     nibble = 4'h2;
            GLYPH_3:     nibble = 4'h3;
            GLYPH_4:     nibble = 4'h4;
            GLYPH_5:     nibble = 4'h5;
            GLYPH_6:     nibble = 4'h6;
            GLYPH_7:     nibble = 4'h7;
            GLYPH_8:     nibble = 4'h8;
            GLYPH_9:     nibble = 4'h9;
            GLYPH_A:     nibble = 4'hA;
            GLYPH_B:     nibble = 4'hB;
            GLYPH_C:     nibble = 4'hC;
            GLYPH_D:     nibble = 4'hD;
            GLYPH_E:     nibble = 4'hE;
            GLYPH_F:     nibble = 4'hF;
            GLYPH_BLANK: is_blank = 1'b1;
            default:     is_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive side of the multiplexed seven-segment bus: filters, decodes and
// reassembles the scanned digits into one 16-bit value per frame.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 4
) (
    input  logic                  div_clk,
    input  logic                  reset,
    input  logic [3:0]            an,
    input  logic [6:0]            seg,
    input  logic                  clear_err,
    output logic [15:0]           value,
    output logic [N_DIGITS-1:0]   seen,
    output logic                  frame_valid,
    output logic                  pattern_err,
    output logic                  anode_err
);

    localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(SETTLE - 1);

    logic [3:0]            an_q, an_d, an_prev_q, an_prev_d;
    logic [6:0]            seg_q, seg_d, seg_prev_q, seg_prev_d;
    logic [1:0]            prime_q, prime_d;
    logic [CNT_W-1:0]      stab_q, stab_d;
    logic [15:0]           shadow_val_q, shadow_val_d, value_q, value_d;
    logic [N_DIGITS-1:0]   shadow_seen_q, shadow_seen_d, seen_q, seen_d;
    logic [1:0]            last_idx_q, last_idx_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  pattern_err_q, pattern_err_d;
    logic                  anode_err_q, anode_err_d;

    logic                  changed, accept;
    logic [1:0]            idx;
    an_class_e             an_class;
    logic [3:0]            nibble;
    logic                  is_blank, is_legal;

    seg7_glyph_decode u_decode (
        .seg      (seg_q),
        .nibble   (nibble),
        .is_blank (is_blank),
        .is_legal (is_legal)
    );

    always_comb begin
        an_d          = an;
        seg_d         = seg;
        an_prev_d     = an_q;
        seg_prev_d    = seg_q;
        prime_d       = {prime_q[0], 1'b1};
        shadow_val_d  = shadow_val_q;
        shadow_seen_d = shadow_seen_q;
        last_idx_d    = last_idx_q;
        value_d       = value_q;
        seen_d        = seen_q;
        frame_valid_d = 1'b0;
        pattern_err_d = clear_err ? 1'b0 : pattern_err_q;
        anode_err_d   = clear_err ? 1'b0 : anode_err_q;

        // prime_q keeps the cleared post-reset registers from posing as a real sample run
        changed = !prime_q[1] || (an_q != an_prev_q) || (seg_q != seg_prev_q);
        if (changed)
            stab_d = '0;
        else if (stab_q == STAB_MAX)
            stab_d = stab_q;
        else
            stab_d = stab_q + 1'b1;
        accept = prime_q[0] && (stab_d == STAB_MAX) && (changed || (stab_q != STAB_MAX));

        idx = 2'd0;
        case (an_q)
            4'b1111: an_class = AN_IDLE;
            4'b1110: an_class = AN_ONE;
            4'b1101: begin an_class = AN_ONE; idx = 2'd1; end
            4'b1011: begin an_class = AN_ONE; idx = 2'd2; end
            4'b0111: begin an_class = AN_ONE; idx = 2'd3; end
            default: an_class = AN_MULTI;
        endcase

        if (accept) begin
            if (an_class == AN_MULTI) begin
                anode_err_d = 1'b1;
            end else if (an_class == AN_ONE) begin
                if (!is_legal) begin
                    pattern_err_d = 1'b1;
                end else begin
                    // A non-increasing index closes the frame before this digit opens the next
                    if (idx <= last_idx_q) begin
                        value_d       = shadow_val_q;
                        seen_d        = shadow_seen_q;
                        frame_valid_d = 1'b1;
                        shadow_seen_d = '0;
                    end
                    if (is_blank) begin
                        shadow_seen_d[idx] = 1'b0;
                    end else begin
                        shadow_val_d[{idx, 2'b00} +: 4] = nibble;
                        shadow_seen_d[idx]              = 1'b1;
                    end
                    last_idx_d = idx;
                end
            end
        end
    end

    always_ff @(posedge div_clk or posedge reset) begin
        if (reset) begin
            an_q          <= '0;
            seg_q         <= '0;
            an_prev_q     <= '0;
            seg_prev_q    <= '0;
            prime_q       <= '0;
            stab_q        <= '0;
            shadow_val_q  <= '0;
            shadow_seen_q <= '0;
            last_idx_q    <= 2'd3;
            value_q       <= '0;
            seen_q        <= '0;
            frame_valid_q <= 1'b0;
            pattern_err_q <= 1'b0;
            anode_err_q   <= 1'b0;
        end else begin
            an_q          <= an_d;
            seg_q         <= seg_d;
            an_prev_q     <= an_prev_d;
            seg_prev_q    <= seg_prev_d;
            prime_q       <= prime_d;
            stab_q        <= stab_d;
            shadow_val_q  <= shadow_val_d;
            shadow_seen_q <= shadow_seen_d;
            last_idx_q    <= last_idx_d;
            value_q       <= value_d;
            seen_q        <= seen_d;
            frame_valid_q <= frame_valid_d;
            pattern_err_q <= pattern_err_d;
            anode_err_q   <= anode_err_d;
        end
    end

    assign value       = value_q;
    assign seen        = seen_q;
    assign frame_valid = frame_valid_q;
    assign pattern_err = pattern_err_q;
    assign anode_err   = anode_err_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench: SETTLE=1 instance driven from a vector table, SETTLE=3
// instance exercised by hand-written hold sequences.
module tb_seven_seg_capture;

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011;
    localparam logic [6:0] GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110, GF = 7'b0001110;
    localparam logic [6:0] BLK = 7'b1111111, BAD = 7'b0110110;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an1, an3;
    logic [6:0]  seg1, seg3;
    logic        clr1, clr3;
    logic [15:0] value1, value3;
    logic [3:0]  seen1, seen3;
    logic        fv1, fv3, perr1, perr3, aerr1, aerr3;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seven_seg_capture #(.SETTLE(1), .CNT_W(4)) dut1 (
        .div_clk(clk), .reset(reset), .an(an1), .seg(seg1), .clear_err(clr1),
        .value(value1), .seen(seen1), .frame_valid(fv1),
        .pattern_err(perr1), .anode_err(aerr1)
    );

    seven_seg_capture #(.SETTLE(3), .CNT_W(4)) dut3 (
        .div_clk(clk), .reset(reset), .an(an3), .seg(seg3), .clear_err(clr3),
        .value(value3), .seen(seen3), .frame_valid(fv3),
        .pattern_err(perr3), .anode_err(aerr3)
    );

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        clr;
        logic        fv;
        logic [15:0] val;
        logic [3:0]  seen;
        logic        perr;
        logic        aerr;
    } vec_t;

    vec_t tbl[36];

    int          fv3_cnt = 0;
    logic [15:0] val3_cap = '0;
    logic [3:0]  seen3_cap = '0;

    always @(negedge clk) begin
        if (fv3 === 1'b1) begin
            fv3_cnt   <= fv3_cnt + 1;
            val3_cap  <= value3;
            seen3_cap <= seen3;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_dut1_zero(input string tag);
        chk({tag, " value"}, 32'(value1), 32'h0);
        chk({tag, " seen"},  32'(seen1),  32'h0);
        chk({tag, " fv"},    32'(fv1),    32'h0);
        chk({tag, " perr"},  32'(perr1),  32'h0);
        chk({tag, " aerr"},  32'(aerr1),  32'h0);
    endtask

    task automatic drive3(input logic [3:0] a, input logic [6:0] s, input int n);
        an3  = a;
        seg3 = s;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{4'b1110, G1,  1'b0, 1'b1, 16'h0000, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{4'b1101, G2,  1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{4'b1011, G3,  1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0};
        tbl[3]  = '{4'b0111, G4,  1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0};
        tbl[4]  = '{4'b1110, G1,  1'b0, 1'b1, 16'h4321, 4'b1111, 1'b0, 1'b0};
        tbl[5]  = '{4'b1101, G2,  1'b0, 1'b0, 16'h4321, 4'b1111, 1'b0, 1'b0};
        tbl[6]  = '{4'b1011, G3,  1'b0, 1'b0, 16'h4321, 4'b1111, 1'b0, 1'b0};
        tbl[7]  = '{4'b0111, G4,  1'b0, 1'b0, 16'h4321, 4'b1111, 1'b0, 1'b0};
        tbl[8]  = '{4'b1110, G1,  1'b0, 1'b1, 16'h4321, 4'b1111, 1'b0, 1'b0};
        tbl[9]  = '{4'b1111, G2,  1'b0, 1'b0, 16'h4321, 4'b1111, 1'b0, 1'b0};
        tbl[10] = '{4'b1101, BLK, 1'b0, 1'b0, 16'h4321, 4'b1111, 1'b0, 1'b0};
        tbl[11] = '{4'b1011, G3,  1'b0, 1'b0, 16'h4321, 4'b1111, 1'b0, 1'b0};
        tbl[12] = '{4'b0111, G4,  1'b0, 1'b0, 16'h4321, 4'b1111, 1'b0, 1'b0};
        tbl[13] = '{4'b1110, G1,  1'b0, 1'b1, 16'h4321, 4'b1101, 1'b0, 1'b0};
        tbl[14] = '{4'b1101, G2,  1'b0, 1'b0, 16'h4321, 4'b1101, 1'b0, 1'b0};
        tbl[15] = '{4'b1011, BAD, 1'b0, 1'b0, 16'h4321, 4'b1101, 1'b1, 1'b0};
        tbl[16] = '{4'b0111, G4,  1'b0, 1'b0, 16'h4321, 4'b1101, 1'b1, 1'b0};
        tbl[17] = '{4'b1110, G1,  1'b0, 1'b1, 16'h4321, 4'b1011, 1'b1, 1'b0};
        tbl[18] = '{4'b1101, G2,  1'b1, 1'b0, 16'h4321, 4'b1011, 1'b0, 1'b0};
        tbl[19] = '{4'b1100, G5,  1'b0, 1'b0, 16'h4321, 4'b1011, 1'b0, 1'b1};
        tbl[20] = '{4'b1011, G3,  1'b0, 1'b0, 16'h4321, 4'b1011, 1'b0, 1'b1};
        tbl[21] = '{4'b0111, G4,  1'b0, 1'b0, 16'h4321, 4'b1011, 1'b0, 1'b1};
        tbl[22] = '{4'b1110, G1,  1'b0, 1'b1, 16'h4321, 4'b1111, 1'b0, 1'b1};
        tbl[23] = '{4'b1001, G0,  1'b1, 1'b0, 16'h4321, 4'b1111, 1'b0, 1'b1};
        tbl[24] = '{4'b1101, G2,  1'b1, 1'b0, 16'h4321, 4'b1111, 1'b0, 1'b0};
        tbl[25] = '{4'b1011, GA,  1'b0, 1'b0, 16'h4321, 4'b1111, 1'b0, 1'b0};
        tbl[26] = '{4'b0111, GF,  1'b0, 1'b0, 16'h4321, 4'b1111, 1'b0, 1'b0};
        tbl[27] = '{4'b1110, G8,  1'b0, 1'b1, 16'hFA21, 4'b1111, 1'b0, 1'b0};
        tbl[28] = '{4'b1101, GB,  1'b0, 1'b0, 16'hFA21, 4'b1111, 1'b0, 1'b0};
        tbl[29] = '{4'b1011, GC,  1'b0, 1'b0, 16'hFA21, 4'b1111, 1'b0, 1'b0};
        tbl[30] = '{4'b0111, GD,  1'b0, 1'b0, 16'hFA21, 4'b1111, 1'b0, 1'b0};
        tbl[31] = '{4'b1110, GE,  1'b0, 1'b1, 16'hDCB8, 4'b1111, 1'b0, 1'b0};
        tbl[32] = '{4'b1101, G6,  1'b0, 1'b0, 16'hDCB8, 4'b1111, 1'b0, 1'b0};
        tbl[33] = '{4'b1011, G7,  1'b0, 1'b0, 16'hDCB8, 4'b1111, 1'b0, 1'b0};
        tbl[34] = '{4'b0111, G9,  1'b0, 1'b0, 16'hDCB8, 4'b1111, 1'b0, 1'b0};
        tbl[35] = '{4'b1110, G0,  1'b0, 1'b1, 16'h976E, 4'b1111, 1'b0, 1'b0};

        reset = 1'b1;
        an1 = 4'b1111; seg1 = BLK; clr1 = 1'b0;
        an3 = 4'b1111; seg3 = BLK; clr3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_dut1_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Each row is held two edges: one to register it, one to accept it.
        for (int i = 0; i < 36; i++) begin
            an1  = tbl[i].an;
            seg1 = tbl[i].seg;
            clr1 = tbl[i].clr;
            @(posedge clk);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d fv", i),   32'(fv1),    32'(tbl[i].fv));
            chk($sformatf("v%0d val", i),  32'(value1), 32'(tbl[i].val));
            chk($sformatf("v%0d seen", i), 32'(seen1),  32'(tbl[i].seen));
            chk($sformatf("v%0d perr", i), 32'(perr1),  32'(tbl[i].perr));
            chk($sformatf("v%0d aerr", i), 32'(aerr1),  32'(tbl[i].aerr));
        end
        clr1 = 1'b0;

        // Asynchronous reset in mid-cycle, observed before any clock edge.
        chk("pre-reset value", 32'(value1), 32'h976E);
        #2;
        reset = 1'b1;
        #1;
        chk_dut1_zero("async reset");
        @(negedge clk);
        reset = 1'b0;
        an1 = 4'b1111; seg1 = BLK;

        // SETTLE=3: a 2-cycle run is rejected, a 10-cycle run accepted once.
        @(negedge clk);
        fv3_cnt = 0;
        drive3(4'b1110, G7, 2);
        drive3(4'b1111, BLK, 6);
        chk("settle short run", 32'(fv3_cnt), 32'd0);
        drive3(4'b1110, G7, 10);
        drive3(4'b1111, BLK, 6);
        chk("settle long run count", 32'(fv3_cnt), 32'd1);
        chk("settle first value", 32'(val3_cap), 32'h0);
        chk("settle first seen", 32'(seen3_cap), 32'h0);
        drive3(4'b1101, G1, 3);
        drive3(4'b1011, G2, 3);
        drive3(4'b0111, G3, 3);
        drive3(4'b1110, G4, 3);
        drive3(4'b1111, BLK, 6);
        chk("settle frame count", 32'(fv3_cnt), 32'd2);
        chk("settle frame value", 32'(val3_cap), 32'h3217);
        chk("settle frame seen", 32'(seen3_cap), 32'hF);
        chk("settle value out", 32'(value3), 32'h3217);
        chk("settle perr", 32'(perr3), 32'h0);
        chk("settle aerr", 32'(aerr3), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
